// File: rtl/aes_pkg.sv
// Shared AES-128 constants, key-expansion state encoding and the round-constant table.
package aes_pkg;

  localparam int unsigned KEY_W   = 128;
  localparam int unsigned NROUNDS = 10;
  localparam int unsigned EXP_W   = KEY_W * (NROUNDS + 1);

  typedef enum logic {
    IDLE,
    RUN
  } ke_state_t;

  function automatic logic [7:0] rcon(input logic [3:0] r);
    logic [7:0] v;
    v = 8'h00;
    case (r)
      4'd1:    v = 8'h01;
      4'd2:    v = 8'h02;
      4'd3:    v = 8'h04;
      4'd4:    v = 8'h08;
      4'd5:    v = 8'h10;
      4'd6:    v = 8'h20;
      4'd7:    v = 8'h40;
      4'd8:    v = 8'h80;
      4'd9:    v = 8'h1b;
      4'd10:   v = 8'h36;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box, one byte in, one byte out.
module aes_sbox (
  input  logic [7:0] value,
  output logic [7:0] result
);

  localparam logic [0:255][7:0] SBOX = {
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign result = SBOX[value];

endmodule

// File: rtl/key_expansion.sv
// Iterative AES-128 key schedule: one round key (four chained words) produced per clock.
module key_expansion
  import aes_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [KEY_W-1:0]     key,
  output logic                 busy,
  output logic                 done,
  output logic [EXP_W-1:0]     expanded_key
);

  ke_state_t         state, state_nxt;
  logic [3:0]        rnd;
  logic [10:0]       prev_base, next_base;
  logic [KEY_W-1:0]  prev_key, round_key;
  logic [31:0]       w0, w1, w2, w3;
  logic [31:0]       rot_word, sub_word, temp;

  // Previous round key lives in the slice just below the one being written.
  always_comb begin
    prev_base = {rnd - 4'd1, 7'd0};
    next_base = {rnd, 7'd0};
    prev_key  = expanded_key[prev_base +: KEY_W];
  end

  assign {w0, w1, w2, w3} = prev_key;
  assign rot_word         = {w3[23:0], w3[31:24]};

  for (genvar i = 0; i < 4; i++) begin : g_subword
    aes_sbox u_sbox (
      .value  (rot_word[8*i +: 8]),
      .result (sub_word[8*i +: 8])
    );
  end

  always_comb begin
    temp      = sub_word ^ {rcon(rnd), 24'h0};
    round_key = '0;
    round_key[127:96] = w0 ^ temp;
    round_key[95:64]  = w1 ^ round_key[127:96];
    round_key[63:32]  = w2 ^ round_key[95:64];
    round_key[31:0]   = w3 ^ round_key[63:32];
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (rnd == 4'(NROUNDS)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      rnd          <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      expanded_key <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            expanded_key <= {{(EXP_W-KEY_W){1'b0}}, key};
            rnd          <= 4'd1;
            busy         <= 1'b1;
            done         <= 1'b0;
          end
        end
        RUN: begin
          expanded_key[next_base +: KEY_W] <= round_key;
          if (rnd == 4'(NROUNDS)) begin
            rnd  <= '0;
            busy <= 1'b0;
            done <= 1'b1;
          end else begin
            rnd <= rnd + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_key_expansion.sv
// Directed bench for key_expansion: FIPS-197 and all-zero key schedules plus control corner cases.
module tb_key_expansion;

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic [127:0]   key;
  logic           busy;
  logic           done;
  logic [1407:0]  expanded_key;

  int total = 0;
  int bad   = 0;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  typedef struct {
    string        name;
    logic [127:0] k;
    logic [127:0] r1;
    logic [127:0] r2;
    logic [127:0] r10;
  } vec_t;

  vec_t vecs [2];

  key_expansion dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .key          (key),
    .busy         (busy),
    .done         (done),
    .expanded_key (expanded_key)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    total++;
    if (busy === 1'b1 && done === 1'b1) begin
      bad++;
      $display("FAIL busy_done_overlap at %0t: busy=%b done=%b (must not both be 1)", $time, busy, done);
    end
  end

  function automatic logic [127:0] rk(input int r);
    return expanded_key[r*128 +: 128];
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives start for exactly one edge and checks the flags right after it.
  task automatic pulse_start(input logic [127:0] k, input string name);
    key   = k;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({name, "_busy_after_start"}, 128'(busy), 128'd1);
    chk({name, "_done_after_start"}, 128'(done), 128'd0);
  endtask

  task automatic wait_done(input int already, input string name);
    int c;
    c = already;
    while (done !== 1'b1 && c < 30) begin
      tick();
      c++;
    end
    chk({name, "_done_latency"}, 128'(c), 128'd10);
    chk({name, "_busy_at_done"}, 128'(busy), 128'd0);
  endtask

  task automatic chk_sched(input vec_t v, input string tag);
    chk({v.name, tag, "_round0"},  rk(0),  v.k);
    chk({v.name, tag, "_round1"},  rk(1),  v.r1);
    chk({v.name, tag, "_round2"},  rk(2),  v.r2);
    chk({v.name, tag, "_round10"}, rk(10), v.r10);
  endtask

  initial begin
    vecs[0] = '{"fips", FIPS_KEY,
                128'ha0fafe1788542cb123a339392a6c7605,
                128'hf2c295f27a96b9435935807a7359f67f,
                128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    vecs[1] = '{"zero", 128'h0,
                128'h62636363626363636263636362636363,
                128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa,
                128'hb4ef5bcb3e92e21123e951cf6f8f188e};

    reset = 1'b1;
    start = 1'b0;
    key   = '0;
    tick();
    tick();
    chk("reset_busy", 128'(busy), 128'd0);
    chk("reset_done", 128'(done), 128'd0);
    chk("reset_ek_zero", 128'(expanded_key == '0), 128'd1);
    reset = 1'b0;
    tick();

    // Back-to-back: second start lands while done=1 and must restart.
    for (int i = 0; i < 2; i++) begin
      pulse_start(vecs[i].k, vecs[i].name);
      wait_done(0, vecs[i].name);
      chk_sched(vecs[i], "");
      chk({vecs[i].name, "_upper_rounds_nonzero"}, 128'(rk(5) != '0), 128'd1);
    end

    for (int i = 0; i < 20; i++) tick();
    chk("hold_done", 128'(done), 128'd1);
    chk_sched(vecs[1], "_hold");

    pulse_start(FIPS_KEY, "ignore");
    for (int i = 0; i < 3; i++) tick();
    key   = 128'h0;
    start = 1'b1;
    tick();
    start = 1'b0;
    key   = 128'hffffffffffffffffffffffffffffffff;
    chk("ignore_still_busy", 128'(busy), 128'd1);
    wait_done(4, "ignore");
    chk_sched(vecs[0], "_ignore");

    pulse_start(128'h0, "abort");
    for (int i = 0; i < 4; i++) tick();
    reset = 1'b1;
    tick();
    chk("abort_busy", 128'(busy), 128'd0);
    chk("abort_done", 128'(done), 128'd0);
    chk("abort_ek_zero", 128'(expanded_key == '0), 128'd1);
    reset = 1'b0;
    pulse_start(FIPS_KEY, "after_reset");
    wait_done(0, "after_reset");
    chk_sched(vecs[0], "_after_reset");

    reset = 1'b1;
    start = 1'b1;
    key   = 128'h0;
    tick();
    chk("reset_prio_busy", 128'(busy), 128'd0);
    chk("reset_prio_done", 128'(done), 128'd0);
    chk("reset_prio_ek_zero", 128'(expanded_key == '0), 128'd1);
    reset = 1'b0;
    start = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    chk("reset_no_late_done", 128'(done), 128'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
